// File: rtl/md_responder.sv
// Multiply/divide responder for the E stage: fixed-latency mult/multu/div/divu that owns HI/LO.
// Requests arriving while busy are dropped here rather than relying on the datapath stall.
module md_responder #(
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10
) (
   input  logic        clk_i,
   input  logic        clr_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        start_i,
   input  logic [1:0]  op_i,
   input  logic        we_i,
   input  logic        wsel_i,
   output logic        busy_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int unsigned CntW   = $clog2(MaxLat + 1);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [31:0]     a_q, a_d, b_q, b_d;
   logic [1:0]      op_q, op_d;
   logic [31:0]     hi_q, hi_d, lo_q, lo_d;

   logic        a_neg, b_neg;
   logic [63:0] prod;
   logic [31:0] a_abs, b_abs, div_den, uquot, urem, quot, rem;

   // op_q[0]=1 selects the unsigned variant for both multiply and divide.
   always_comb begin
      a_neg   = ~op_q[0] & a_q[31];
      b_neg   = ~op_q[0] & b_q[31];
      prod    = {{32{a_neg}}, a_q} * {{32{b_neg}}, b_q};
      a_abs   = a_neg ? (32'd0 - a_q) : a_q;
      b_abs   = b_neg ? (32'd0 - b_q) : b_q;
      div_den = (b_q == 32'd0) ? 32'd1 : b_abs;
      uquot   = a_abs / div_den;
      urem    = a_abs % div_den;
      quot    = (a_neg ^ b_neg) ? (32'd0 - uquot) : uquot;
      rem     = a_neg ? (32'd0 - urem) : urem;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         StIdle: begin
            if (start_i) begin
               a_d     = a_i;
               b_d     = b_i;
               op_d    = op_i;
               cnt_d   = op_i[1] ? CntW'(DIV_LAT) : CntW'(MULT_LAT);
               state_d = StRun;
            end else if (we_i) begin
               if (wsel_i) hi_d = a_i;
               else        lo_d = a_i;
            end
         end
         StRun: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) begin
               state_d = StIdle;
               if (!op_q[1]) begin
                  {hi_d, lo_d} = prod;
               end else if (b_q != 32'd0) begin
                  lo_d = quot;
                  hi_d = rem;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy_o = (state_q == StRun);
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: tb/tb_md_responder.sv
// Bench for md_responder: directed vector table, hand-written corner sequences and
// randomized traffic compared against an arithmetic reference model.
module tb_md_responder;

   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 10;

   logic        clk = 1'b0;
   logic        clr, start, we, wsel;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        busy;
   logic [31:0] hi, lo;

   md_responder #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk_i  (clk),
      .clr_i  (clr),
      .a_i    (a),
      .b_i    (b),
      .start_i(start),
      .op_i   (op),
      .we_i   (we),
      .wsel_i (wsel),
      .busy_o (busy),
      .hi_o   (hi),
      .lo_o   (lo)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   logic        m_busy;
   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   bit          p_skip;
   int          m_rem;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   function automatic void md_compute(input logic [1:0] o, input logic [31:0] x,
                                      input logic [31:0] y, output logic [31:0] rhi,
                                      output logic [31:0] rlo, output bit skip);
      longint          sx, sy, sp;
      longint unsigned ux, uy, up;
      sx = $signed(x);
      sy = $signed(y);
      ux = {32'd0, x};
      uy = {32'd0, y};
      skip = 1'b0;
      rhi = 32'd0;
      rlo = 32'd0;
      case (o)
         2'b00: begin sp = sx * sy; {rhi, rlo} = sp; end
         2'b01: begin up = ux * uy; {rhi, rlo} = up; end
         2'b10: begin
            if (y == 32'd0) skip = 1'b1;
            else begin sp = sx / sy; rlo = sp[31:0]; sp = sx % sy; rhi = sp[31:0]; end
         end
         default: begin
            if (y == 32'd0) skip = 1'b1;
            else begin up = ux / uy; rlo = up[31:0]; up = ux % uy; rhi = up[31:0]; end
         end
      endcase
   endfunction

   task automatic model_edge();
      if (clr) begin
         m_busy = 1'b0; m_hi = 32'd0; m_lo = 32'd0; m_rem = 0;
      end else if (m_busy) begin
         m_rem--;
         if (m_rem == 0) begin
            m_busy = 1'b0;
            if (!p_skip) begin m_hi = p_hi; m_lo = p_lo; end
         end
      end else if (start) begin
         md_compute(op, a, b, p_hi, p_lo, p_skip);
         m_rem  = op[1] ? DIV_LAT : MULT_LAT;
         m_busy = 1'b1;
      end else if (we) begin
         if (wsel) m_hi = a;
         else      m_lo = a;
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".busy"}, {31'd0, busy}, {31'd0, m_busy});
      check({tag, ".hi"}, hi, m_hi);
      check({tag, ".lo"}, lo, m_lo);
   endtask

   task automatic idle_inputs();
      clr = 1'b0; start = 1'b0; we = 1'b0; wsel = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
   endtask

   // Issue one op and count busy cycles (bounded), checking model agreement along the way.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, output int nbusy);
      start = 1'b1; op = o; a = x; b = y;
      tick();
      start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; op = ~o;
      nbusy = 0;
      while (busy && nbusy < 40) begin
         check_all({tag, ".run"});
         nbusy++;
         tick();
      end
   endtask

   initial begin
      int nb;
      vecs[0] = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_LAT};
      vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MULT_LAT};
      vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT};
      vecs[3] = '{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, DIV_LAT};
      vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT};
      vecs[5] = '{2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, MULT_LAT};
      vecs[6] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_LAT};

      idle_inputs();
      clr = 1'b1;
      tick();
      tick();
      clr = 1'b0;
      check("reset.busy", {31'd0, busy}, 32'd0);
      check("reset.hi", hi, 32'd0);
      check("reset.lo", lo, 32'd0);

      foreach (vecs[i]) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, nb);
         check($sformatf("vec%0d.lat", i), nb, vecs[i].lat);
         check($sformatf("vec%0d.hi", i), hi, vecs[i].hi);
         check($sformatf("vec%0d.lo", i), lo, vecs[i].lo);
      end

      // mthi / mtlo, then divide by zero leaves HI/LO alone
      we = 1'b1; wsel = 1'b1; a = 32'h1234_5678;
      tick();
      wsel = 1'b0; a = 32'hCAFE_0001;
      tick();
      we = 1'b0;
      check("mthi.hi", hi, 32'h1234_5678);
      check("mtlo.lo", lo, 32'hCAFE_0001);
      run_op("div0", 2'b10, 32'd5, 32'd0, nb);
      check("div0.lat", nb, DIV_LAT);
      check("div0.hi", hi, 32'h1234_5678);
      check("div0.lo", lo, 32'hCAFE_0001);

      // start and we during busy are both ignored
      start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7; we = 1'b1; wsel = 1'b1;
      tick();
      idle_inputs();
      nb = 3;
      while (busy && nb < 40) begin nb++; tick(); end
      check("ignore.lat", nb, MULT_LAT + 1);
      check("ignore.hi", hi, 32'd0);
      check("ignore.lo", lo, 32'd12);
      check_all("ignore");

      // start and we together in IDLE: write dropped
      start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd5; we = 1'b1; wsel = 1'b0;
      tick();
      idle_inputs();
      check("startwe.busy", {31'd0, busy}, 32'd1);
      check("startwe.lo_hold", lo, 32'd12);
      nb = 0;
      while (busy && nb < 40) begin nb++; tick(); end
      check("startwe.lo", lo, 32'd10);

      // clr mid-divide cancels the result
      start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
      tick();
      idle_inputs();
      tick(); tick(); tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("abort.busy", {31'd0, busy}, 32'd0);
      check("abort.hi", hi, 32'd0);
      check("abort.lo", lo, 32'd0);
      repeat (12) tick();
      check_all("abort.after");
      check("abort.lo_final", lo, 32'd0);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         clr   = ($urandom_range(0, 199) == 0);
         start = ($urandom_range(0, 7) == 0);
         we    = ($urandom_range(0, 3) == 0);
         wsel  = $urandom_range(0, 1);
         op    = 2'($urandom_range(0, 3));
         a     = $urandom();
         b     = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom();
         if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
         tick();
         check_all("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
